// File: rtl/lif_spike_generator.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | lif_spike_generator: leaky integrate-and-fire output stage; 4 timesteps/packet, FIFO in, |
// | valid/ready spike vector out. Optional macro SOFT_RESET_EN selects subtractive reset.    |
// | Revision: 1.0                                                                            |
// +------------------------------------------------------------------------------------------+
module lif_spike_generator #(
  parameter int TIMESTEPS            = 4,
  parameter int CORRECTION_ACC_WIDTH = 10,
  parameter int MEM_WIDTH            = 12,
  parameter int LEAK_SHIFT           = 2,
  parameter int FIFO_DEPTH           = 2,
  parameter int ADDR_WIDTH           = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            layer_start,
  input  logic [MEM_WIDTH-1:0]            threshold,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_0,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_1,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_2,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_3,
  input  logic                            result_valid,
  output logic [TIMESTEPS-1:0]            spike_out,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            fifo_overflow
);

  localparam int CW   = CORRECTION_ACC_WIDTH;
  localparam int PKW  = TIMESTEPS * CW;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int TW   = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, INTEG = 2'd1, EMIT = 2'd2} state_t;

  state_t                state;
  logic [PKW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNTW-1:0]       count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [PKW-1:0]        pkt;
  logic [MEM_WIDTH-1:0]  thr;
  logic [MEM_WIDTH-1:0]  v;
  logic [TW-1:0]         t;
  logic [TIMESTEPS-1:0]  spikes;
  logic [ADDR_WIDTH-1:0] index;

  logic [MEM_WIDTH-1:0]  leak;
  logic [MEM_WIDTH-1:0]  in_t;
  logic [MEM_WIDTH:0]    sum;
  logic [MEM_WIDTH-1:0]  vn;
  logic [MEM_WIDTH-1:0]  v_next;
  logic                  fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still takes a packet when the head leaves in the same cycle.
  assign push       = result_valid && (!fifo_full || pop);
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {result_3, result_2, result_1, result_0};
  end

  // The packet register shifts down one sample per step, so the current input is always at the bottom.
  always_comb begin
    in_t = MEM_WIDTH'(pkt[CW-1:0]);
    leak = (LEAK_SHIFT == 0) ? '0 : (v >> LEAK_SHIFT);
    sum  = {1'b0, v - leak} + {1'b0, in_t};
    vn   = sum[MEM_WIDTH] ? '1 : sum[MEM_WIDTH-1:0];
    fire = (vn >= thr);
`ifdef SOFT_RESET_EN
    v_next = fire ? (vn - thr) : vn;
`else
    v_next = fire ? '0 : vn;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
      pkt           <= '0;
      thr           <= '0;
      v             <= '0;
      t             <= '0;
      spikes        <= '0;
      spike_out     <= '0;
      out_addr      <= '0;
      out_valid     <= 1'b0;
      index         <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNTW'(1);
      else if (pop && !push) count <= count - CNTW'(1);

      if (result_valid && !push) fifo_overflow <= 1'b1;
      else if (layer_start)      fifo_overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            pkt   <= mem[rd_ptr];
            thr   <= threshold;
            v     <= '0;
            t     <= '0;
            state <= INTEG;
          end
        end
        INTEG: begin
          v      <= v_next;
          pkt    <= pkt >> CW;
          t      <= t + 1'b1;
          spikes <= {fire, spikes[TIMESTEPS-1:1]};
          if (t == TW'(TIMESTEPS - 1)) begin
            spike_out <= {fire, spikes[TIMESTEPS-1:1]};
            out_addr  <= index;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            index     <= index + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (layer_start) index <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lif_spike_generator.sv
`default_nettype none
// Self-checking bench for lif_spike_generator: hand vectors, corner sequences and a random stream
// compared against an arithmetic membrane model.
module tb_lif_spike_generator;
  localparam int CW = 10;
  localparam int MW = 12;
  localparam int LS = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          layer_start;
  logic [MW-1:0] threshold;
  logic [CW-1:0] result_0, result_1, result_2, result_3;
  logic          result_valid;
  logic [3:0]    spike_out;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          fifo_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lif_spike_generator #(
    .TIMESTEPS(4), .CORRECTION_ACC_WIDTH(CW), .MEM_WIDTH(MW),
    .LEAK_SHIFT(LS), .FIFO_DEPTH(2), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .threshold(threshold),
    .result_0(result_0), .result_1(result_1), .result_2(result_2), .result_3(result_3),
    .result_valid(result_valid), .spike_out(spike_out), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .fifo_overflow(fifo_overflow)
  );

  typedef struct packed {
    logic [9:0]  r0, r1, r2, r3;
    logic [11:0] thr;
    logic [3:0]  exp_hard;
    logic [3:0]  exp_soft;
  } vec_t;

  vec_t vecs [8];

  // Membrane model straight from the firing rules, in plain integer arithmetic.
  function automatic logic [3:0] model(input int r0, input int r1, input int r2, input int r3,
                                       input int thr);
    int r [4];
    int v, vn, leak;
    logic [3:0] s;
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    v = 0;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      leak = (LS == 0) ? 0 : v / (1 << LS);
      vn = v - leak + r[k];
      if (vn > (1 << MW) - 1) vn = (1 << MW) - 1;
      if (vn >= thr) begin
        s[k] = 1'b1;
`ifdef SOFT_RESET_EN
        v = vn - thr;
`else
        v = 0;
`endif
      end else begin
        v = vn;
      end
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int r0, input int r1, input int r2, input int r3, input int thr);
    result_0 = CW'(r0); result_1 = CW'(r1); result_2 = CW'(r2); result_3 = CW'(r3);
    threshold = MW'(thr);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  // Waits for out_valid, captures, then lets the handshake edge pass (out_ready assumed high).
  task automatic wait_out(output logic [3:0] s, output logic [AW-1:0] a);
    logic found;
    found = 1'b0;
    s = '0;
    a = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid) begin
        s = spike_out;
        a = out_addr;
        found = 1'b1;
        step();
      end else begin
        step();
      end
    end
    check("out_valid_seen", 32'(found), 32'd1);
  endtask

  task automatic run_pkt(input vec_t vv, input logic [3:0] exp_s, input int exp_a);
    logic [3:0] s;
    logic [AW-1:0] a;
    send(vv.r0, vv.r1, vv.r2, vv.r3, vv.thr);
    repeat (4) step();
    check("latency_n5_low", 32'(out_valid), 32'd0);
    step();
    check("latency_n6_high", 32'(out_valid), 32'd1);
    wait_out(s, a);
    check("vec_spikes", 32'(s), 32'(exp_s));
    check("vec_addr", 32'(a), 32'(exp_a));
  endtask

  initial begin
    logic [3:0] s, exp_s;
    logic [AW-1:0] a;
    int exp_idx, r0, r1, r2, r3, thr;
    logic seen;

    vecs[0] = '{10'd10,   10'd10,   10'd10, 10'd10, 12'd20,   4'b0100, 4'b0100};
    vecs[1] = '{10'd30,   10'd15,   10'd0,  10'd0,  12'd20,   4'b0001, 4'b0011};
    vecs[2] = '{10'd5,    10'd0,    10'd7,  10'd1,  12'd0,    4'b1111, 4'b1111};
    vecs[3] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 12'd4095, 4'b0000, 4'b0000};
    vecs[4] = '{10'd1023, 10'd0,    10'd0,  10'd0,  12'd1000, 4'b0001, 4'b0001};
    vecs[5] = '{10'd0,    10'd0,    10'd0,  10'd1,  12'd1,    4'b1000, 4'b1000};
    vecs[6] = '{10'd1023, 10'd1023, 10'd0,  10'd0,  12'd2000, 4'b0000, 4'b0000};
    vecs[7] = '{10'd40,   10'd20,   10'd40, 10'd20, 12'd50,   4'b1010, 4'b1010};

    rst = 1'b1; layer_start = 1'b0; result_valid = 1'b0; out_ready = 1'b1;
    threshold = '0; result_0 = '0; result_1 = '0; result_2 = '0; result_3 = '0;
    repeat (3) step();
    check("rst_spike_out", 32'(spike_out), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(fifo_overflow), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
`ifdef SOFT_RESET_EN
      exp_s = vecs[i].exp_soft;
`else
      exp_s = vecs[i].exp_hard;
`endif
      run_pkt(vecs[i], exp_s, i);
    end

    // Backpressure: one held in EMIT, two buffered, the fourth dropped.
    layer_start = 1'b1; step(); layer_start = 1'b0;
    out_ready = 1'b0;
    send(vecs[0].r0, vecs[0].r1, vecs[0].r2, vecs[0].r3, 20); step();
    send(vecs[1].r0, vecs[1].r1, vecs[1].r2, vecs[1].r3, 20); step();
    send(vecs[7].r0, vecs[7].r1, vecs[7].r2, vecs[7].r3, 20); step();
    send(900, 900, 900, 900, 20);
    check("bp_overflow", 32'(fifo_overflow), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    repeat (3) step();
    check("bp_spikes_stable", 32'(spike_out), 32'(model(10, 10, 10, 10, 20)));
    check("bp_addr_stable", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    wait_out(s, a);
    check("bp_p1_spikes", 32'(s), 32'(model(10, 10, 10, 10, 20)));
    check("bp_p1_addr", 32'(a), 32'd0);
    wait_out(s, a);
    check("bp_p2_spikes", 32'(s), 32'(model(30, 15, 0, 0, 20)));
    check("bp_p2_addr", 32'(a), 32'd1);
    wait_out(s, a);
    check("bp_p3_spikes", 32'(s), 32'(model(40, 20, 40, 20, 20)));
    check("bp_p3_addr", 32'(a), 32'd2);
    repeat (8) step();
    check("bp_no_fourth", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_overflow_sticky", 32'(fifo_overflow), 32'd1);
    layer_start = 1'b1; step(); layer_start = 1'b0;
    check("ls_clears_overflow", 32'(fifo_overflow), 32'd0);

    // Random stream through an address wrap.
    exp_idx = 0;
    for (int k = 0; k < 258; k++) begin
      r0 = $urandom_range(0, 600); r1 = $urandom_range(0, 600);
      r2 = $urandom_range(0, 600); r3 = $urandom_range(0, 600);
      thr = $urandom_range(0, 1500);
      send(r0, r1, r2, r3, thr);
      wait_out(s, a);
      check("rnd_spikes", 32'(s), 32'(model(r0, r1, r2, r3, thr)));
      check("rnd_addr", 32'(a), 32'(exp_idx));
      exp_idx = (exp_idx + 1) % 256;
    end

    // layer_start on the same edge as an EMIT handshake: clear wins.
    send(10, 10, 10, 10, 20);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check("hs_valid", 32'(out_valid), 32'd1);
    layer_start = 1'b1; step(); layer_start = 1'b0;
    check("hs_done", 32'(out_valid), 32'd0);
    send(10, 10, 10, 10, 20);
    wait_out(s, a);
    check("clear_wins_addr", 32'(a), 32'd0);

    // Reset mid-INTEG with a second packet buffered.
    send(10, 10, 10, 10, 20); step();
    send(30, 15, 0, 0, 20);
    rst = 1'b1;
    #2;
    check("mid_rst_spike_out", 32'(spike_out), 32'd0);
    check("mid_rst_out_addr", 32'(out_addr), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid || busy) seen = 1'b1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    run_pkt(vecs[0], 4'b0100, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
